// File: rtl/soc_mmio_uart_tx_if.sv
// Data-memory bus slice seen by the MMIO UART: the core side issues reads/writes,
// the UART answers with registered read data and a hit flag for the SoC read mux.
interface soc_mmio_uart_tx_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteenable;
    logic        w_en;
    logic        r_en;
    logic [31:0] rdata;
    logic        rd_hit;

    modport master (
        output addr, wdata, byteenable, w_en, r_en,
        input  rdata, rd_hit
    );

    modport slave (
        input  addr, wdata, byteenable, w_en, r_en,
        output rdata, rd_hit
    );
endinterface

// File: rtl/soc_mmio_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO, programmable baud divisor, sticky overflow, TX-done IRQ.
// Optional UART_SIM_PRINT_EN echoes every accepted TXDATA byte to the simulator console.
module soc_mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0080_0000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic              clk,
    input  logic              rst,
    soc_mmio_uart_tx_if.slave bus,
    output logic              tx,
    output logic              irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_nxt;
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic        full, empty, hit, wr_ok, push, pop;
    logic        sel_txdata, sel_status, sel_baud, sel_ctrl;
    logic        overflow, irq_en, busy, bit_done, tx_nxt;
    logic [15:0] baud_div, div_q, cyc_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shifter;
    logic [31:0] status, rd_val;
    logic        unused_bits;

    assign hit        = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign wr_ok      = bus.w_en & hit & bus.byteenable[0];
    assign sel_txdata = (bus.addr[3:0] == 4'h0);
    assign sel_status = (bus.addr[3:0] == 4'h4);
    assign sel_baud   = (bus.addr[3:0] == 4'h8);
    assign sel_ctrl   = (bus.addr[3:0] == 4'hC);

    // Full is taken from the pre-pop count, so a push into a full FIFO drops even if a pop happens too.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW + 1)'(FIFO_DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign push  = wr_ok & sel_txdata & ~full;

    assign busy     = (state != IDLE);
    assign bit_done = (cyc_cnt == div_q);
    assign irq      = irq_en & empty & ~busy;

    assign unused_bits = ^{bus.wdata[31:16], bus.byteenable[3:1]};

    // NOTE: FIFO storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= bus.wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            baud_div <= DEFAULT_DIV;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
            if (wr_ok && sel_txdata && full) begin
                overflow <= 1'b1;
            end else if (wr_ok && sel_status && bus.wdata[3]) begin
                overflow <= 1'b0;
            end
            if (wr_ok && sel_baud) baud_div <= bus.wdata[15:0];
            if (wr_ok && sel_ctrl) irq_en   <= bus.wdata[0];
        end
    end

    // NOTE: combinational processes assign every output a default first, so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = START;
                    pop       = 1'b1;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (bit_done) state_nxt = DATA;
            end
            DATA: begin
                tx_nxt = shifter[0];
                if (bit_done && bit_cnt == 3'd7) state_nxt = STOP;
            end
            STOP: begin
                if (bit_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shifter <= '0;
            div_q   <= DEFAULT_DIV;
        end else begin
            state <= state_nxt;
            tx    <= tx_nxt;
            if (pop) begin
                shifter <= fifo_mem[rd_ptr[AW-1:0]];
                div_q   <= baud_div;
                cyc_cnt <= '0;
                bit_cnt <= '0;
            end else if (busy) begin
                if (bit_done) begin
                    cyc_cnt <= '0;
                    if (state == DATA) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shifter <= {1'b0, shifter[7:1]};
                    end
                end else begin
                    cyc_cnt <= cyc_cnt + 16'd1;
                end
            end
        end
    end

    assign status = {16'h0, 8'(count), 4'h0, overflow, busy, empty, full};

    always_comb begin
        rd_val = '0;
        if (sel_status)    rd_val = status;
        else if (sel_baud) rd_val = {16'h0, baud_div};
        else if (sel_ctrl) rd_val = {31'h0, irq_en};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.rdata  <= '0;
            bus.rd_hit <= 1'b0;
        end else if (bus.r_en && hit) begin
            bus.rdata  <= rd_val;
            bus.rd_hit <= 1'b1;
        end else begin
            bus.rdata  <= '0;
            bus.rd_hit <= 1'b0;
        end
    end

`ifdef UART_SIM_PRINT_EN
    always_ff @(posedge clk) begin
        if (rst && push) $write("%c", bus.wdata[7:0]);
    end
`else
`endif

endmodule

// File: tb/tb_soc_mmio_uart_tx.sv
// Self-checking bench for soc_mmio_uart_tx: register vector table, hand-built corner sequences,
// and randomized traffic decoded from the serial line against an expected-frame queue.
module tb_soc_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h0080_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx, irq;

    soc_mmio_uart_tx_if bus_if ();

    soc_mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (16),
        .DEFAULT_DIV(16'd433)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if),
        .tx (tx),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected serial frames: byte plus the divisor that frame must use.
    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    frame_t exp_q[$];
    bit     mon_en = 1'b0;

    task automatic expect_frame(input logic [7:0] b, input int div);
        frame_t f;
        f.data = b;
        f.div  = div;
        exp_q.push_back(f);
    endtask

    // Line decoder: every bit must hold for exactly div+1 cycles, start 0, LSB first, stop 1.
    initial begin : tx_monitor
        frame_t     f;
        logic [9:0] bits;
        int         bad;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 64'd1, 64'd0);
                end else begin
                    f       = exp_q.pop_front();
                    bits    = {1'b1, f.data, 1'b0};
                    bad     = 0;
                    aborted = 1'b0;
                    for (int i = 0; i < 10 && !aborted; i++) begin
                        for (int j = 0; j <= f.div && !aborted; j++) begin
                            if (i != 0 || j != 0) @(negedge clk);
                            if (!mon_en) aborted = 1'b1;
                            else if (tx !== bits[i]) bad++;
                        end
                    end
                    if (!aborted) check($sformatf("frame_%02h_div%0d", f.data, f.div), 64'(bad), 64'd0);
                end
            end
        end
    end

    // Bus tasks are entered at a falling edge and return at the next falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_if.addr       = a;
        bus_if.wdata      = d;
        bus_if.byteenable = be;
        bus_if.w_en       = 1'b1;
        @(negedge clk);
        bus_if.w_en       = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        bus_if.addr = a;
        bus_if.r_en = 1'b1;
        @(negedge clk);
        bus_if.r_en = 1'b0;
        d = bus_if.rdata;
        h = bus_if.rd_hit;
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] s;
        logic        h;
        int          n;
        n = 0;
        do begin
            bus_read(BASE + 32'h4, s, h);
            n++;
        end while (((s & 32'h6) != 32'h2) && n < 20000);
        check({name, "_idle"}, 64'(s & 32'h7), 64'h2);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [32:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic [32:0] exp, input string nm);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.be = be; v.exp = exp; v.name = nm;
        vecs.push_back(v);
    endfunction

    initial begin : main
        logic [31:0] d;
        logic        h;
        logic [7:0]  b;
        int          k, div, n;
        bit          low_seen;

        bus_if.addr = '0; bus_if.wdata = '0; bus_if.byteenable = '0;
        bus_if.w_en = 1'b0; bus_if.r_en = 1'b0;

        // exp = {rd_hit, rdata}
        add(0, BASE + 32'h4,  0,             4'h0, {1'b1, 32'h2},   "rst_status");
        add(0, BASE + 32'h8,  0,             4'h0, {1'b1, 32'h1B1}, "rst_baud");
        add(0, BASE + 32'hC,  0,             4'h0, {1'b1, 32'h0},   "rst_ctrl");
        add(0, BASE,          0,             4'h0, {1'b1, 32'h0},   "txdata_read");
        add(0, BASE + 32'h10, 0,             4'h0, {1'b0, 32'h0},   "outside_window");
        add(1, BASE + 32'h8,  32'h1234,      4'hE, 33'h0,           "");
        add(0, BASE + 32'h8,  0,             4'h0, {1'b1, 32'h1B1}, "baud_be0_ignored");
        add(1, BASE + 32'h8,  32'hABCD_0005, 4'h1, 33'h0,           "");
        add(0, BASE + 32'h8,  0,             4'h0, {1'b1, 32'h5},   "baud_write");
        add(1, BASE + 32'hC,  32'hFFFF_FFFF, 4'h1, 33'h0,           "");
        add(0, BASE + 32'hC,  0,             4'h0, {1'b1, 32'h1},   "ctrl_set");
        add(1, BASE + 32'hC,  32'h0,         4'h1, 33'h0,           "");
        add(0, BASE + 32'hC,  0,             4'h0, {1'b1, 32'h0},   "ctrl_clear");
        add(1, BASE + 32'h2,  32'hFF,        4'h1, 33'h0,           "");
        add(0, BASE + 32'h2,  0,             4'h0, {1'b1, 32'h0},   "unmapped_offset");
        add(1, BASE + 32'h18, 32'h9,         4'h1, 33'h0,           "");
        add(0, BASE + 32'h8,  0,             4'h0, {1'b1, 32'h5},   "write_outside_ignored");
        add(1, BASE + 32'h4,  32'hFFFF_FFFF, 4'h1, 33'h0,           "");
        add(1, BASE + 32'h8,  32'h3,         4'h1, 33'h0,           "");
        add(0, BASE + 32'h4,  0,             4'h0, {1'b1, 32'h2},   "status_readonly");
        add(0, BASE + 32'h8,  0,             4'h0, {1'b1, 32'h3},   "baud_div3");

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_tx",     64'(tx), 64'd1);
        check("reset_irq",    64'(irq), 64'd0);
        check("reset_rd_hit", 64'(bus_if.rd_hit), 64'd0);
        check("reset_rdata",  64'(bus_if.rdata), 64'd0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            end else begin
                bus_read(vecs[i].addr, d, h);
                check(vecs[i].name, 64'({h, d}), 64'(vecs[i].exp));
            end
        end
        @(negedge clk);
        check("rd_hit_drop", 64'(bus_if.rd_hit), 64'd0);

        mon_en = 1'b1;

        // 0x55 at DIV=3: start visible two edges after the push edge, busy with empty FIFO mid-frame.
        expect_frame(8'h55, 3);
        bus_write(BASE, 32'h55, 4'h1);
        @(negedge clk);
        check("latency_n1_high", 64'(tx), 64'd1);
        @(negedge clk);
        check("latency_n2_low", 64'(tx), 64'd0);
        bus_read(BASE + 32'h4, d, h);
        check("status_busy_empty", 64'(d), 64'h6);
        wait_idle("frame55");

        // Overflow: 18 back-to-back pushes at DIV=1000; the last one is dropped.
        bus_write(BASE + 32'h8, 32'd1000, 4'h1);
        for (int i = 1; i <= 18; i++) begin
            if (i == 1)       expect_frame(8'(8'h10 + i), 1000);
            else if (i <= 17) expect_frame(8'(8'h10 + i), 0);
            bus_write(BASE, 32'(8'h10 + i), 4'h1);
        end
        bus_read(BASE + 32'h4, d, h);
        check("status_full_ovf", 64'(d), 64'h100D);
        bus_write(BASE + 32'h4, 32'h8, 4'h1);
        bus_read(BASE + 32'h4, d, h);
        check("status_ovf_cleared", 64'(d), 64'h1005);
        bus_write(BASE + 32'h8, 32'd0, 4'h1);
        wait_idle("overflow");

        // Divisor change mid-frame applies only from the next frame.
        bus_write(BASE + 32'h8, 32'd3, 4'h1);
        expect_frame(8'hA3, 3);
        expect_frame(8'h3C, 7);
        bus_write(BASE, 32'hA3, 4'h1);
        bus_write(BASE, 32'h3C, 4'h1);
        repeat (6) @(negedge clk);
        bus_write(BASE + 32'h8, 32'd7, 4'h1);
        bus_read(BASE + 32'h8, d, h);
        check("baud_midframe_read", 64'(d), 64'd7);
        wait_idle("baud_change");

        // IRQ: high only once the FIFO is drained and the second stop bit is over.
        bus_write(BASE + 32'h8, 32'd2, 4'h1);
        bus_write(BASE + 32'hC, 32'h1, 4'h1);
        check("irq_idle_enabled", 64'(irq), 64'd1);
        expect_frame(8'h81, 2);
        expect_frame(8'h7E, 2);
        bus_write(BASE, 32'h81, 4'h1);
        bus_write(BASE, 32'h7E, 4'h1);
        k = 0;
        while (irq !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("irq_rise_cycle", 64'(k), 64'(1 + 20 * (2 + 1)));
        bus_write(BASE + 32'hC, 32'h0, 4'h1);
        check("irq_cleared", 64'(irq), 64'd0);
        wait_idle("irq");

        // Randomized traffic.
        for (int it = 0; it < 6; it++) begin
            div = $urandom_range(0, 4);
            n   = $urandom_range(1, 8);
            bus_write(BASE + 32'h8, 32'(div), 4'h1);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                expect_frame(b, div);
                bus_write(BASE, {24'($urandom), b}, 4'h1);
            end
            wait_idle($sformatf("rand%0d", it));
        end
        check("frames_pending", 64'(exp_q.size()), 64'd0);

        // Reset during DATA bit 3 of 0xF7 (bit 3 is 0): line returns high, frame and FIFO gone.
        mon_en = 1'b0;
        repeat (2) @(negedge clk);
        bus_write(BASE + 32'h8, 32'd3, 4'h1);
        bus_write(BASE, 32'hF7, 4'h1);
        bus_write(BASE, 32'h12, 4'h1);
        repeat (18) @(negedge clk);
        check("abort_bit3_low", 64'(tx), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_tx_high", 64'(tx), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        bus_read(BASE + 32'h4, d, h);
        check("abort_status", 64'(d), 64'h2);
        bus_read(BASE + 32'h8, d, h);
        check("abort_baud_default", 64'(d), 64'h1B1);
        low_seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        check("abort_no_frame", 64'(low_seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
